// File: rtl/flash_pkg.sv
// Shared constants for the SPI flash program sequencer: opcodes, driver
// command types (bit3 = go), FSM encoding and error codes.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_PP   = 8'h02;

  localparam logic [3:0] CT_IDLE      = 4'b0000;
  localparam logic [3:0] CT_CMD_ONLY  = 4'b1001;
  localparam logic [3:0] CT_CMD_ADDR  = 4'b1100;
  localparam logic [3:0] CT_RD_NOADDR = 4'b1011;
  localparam logic [3:0] CT_WR_ADDR   = 4'b1101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_WREN   = 3'd2;
  localparam logic [2:0] ST_ERASE  = 3'd3;
  localparam logic [2:0] ST_POLL   = 3'd4;
  localparam logic [2:0] ST_PROG   = 3'd5;
  localparam logic [2:0] ST_NEXT   = 3'd6;
  localparam logic [2:0] ST_FINISH = 3'd7;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_POLL_TO  = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;

endpackage

// File: rtl/flash_chunk_calc.sv
// Combinational page-chunk size and sector-erase decision for the current
// program position.
module flash_chunk_calc
  import flash_pkg::*;
#(
  parameter int PAGE_BYTES   = 256,
  parameter int SECTOR_BYTES = 4096
) (
  input  logic [23:0] i_cur_addr,
  input  logic [23:0] i_remaining,
  input  logic        i_first,
  output logic [23:0] o_chunk,
  output logic        o_erase_needed
);

  localparam logic [23:0] PAGE_SZ   = 24'(PAGE_BYTES);
  localparam logic [23:0] PAGE_MASK = 24'(PAGE_BYTES - 1);
  localparam logic [23:0] SECT_MASK = 24'(SECTOR_BYTES - 1);

  logic [23:0] room;

  always_comb begin
    room           = PAGE_SZ - (i_cur_addr & PAGE_MASK);
    o_chunk        = (i_remaining < room) ? i_remaining : room;
    o_erase_needed = i_first | ((i_cur_addr & SECT_MASK) == 24'd0);
  end

endmodule

// File: rtl/flash_prog_seq.sv
// Turns one "write N bytes at address A" request into WREN / sector-erase /
// page-program / status-poll commands for the SPI flash driver.
module flash_prog_seq
  import flash_pkg::*;
#(
  parameter int          PAGE_BYTES   = 256,
  parameter int          SECTOR_BYTES = 4096,
  parameter logic [15:0] POLL_MAX     = 16'd60000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [23:0] i_base_addr,
  input  logic [23:0] i_len,
  input  logic [7:0]  i_wr_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic [3:0]  o_cmd_type,
  output logic [7:0]  o_flash_cmd,
  output logic [23:0] o_flash_addr,
  output logic [7:0]  o_flash_data,
  output logic [7:0]  o_data_num,
  input  logic        i_wr_byte_over,
  input  logic        i_op_done,
  input  logic        i_flash_done,
  input  logic [7:0]  i_flash_data
);

  logic [2:0]  state_q, state_d;
  logic        ret_q, ret_d;
  logic        active_q, active_d;
  logic [23:0] cur_addr_q, cur_addr_d;
  logic [23:0] remaining_q, remaining_d;
  logic        first_q, first_d;
  logic [23:0] chunk_q, chunk_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        wip_q, wip_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  cmd_type_q, cmd_type_d;
  logic [7:0]  flash_cmd_q, flash_cmd_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic [7:0]  flash_data_q, flash_data_d;
  logic [7:0]  data_num_q, data_num_d;
  logic        wr_ready_q, wr_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] calc_chunk;
  logic        calc_erase;
  logic        wip_now;

  flash_chunk_calc #(
    .PAGE_BYTES   (PAGE_BYTES),
    .SECTOR_BYTES (SECTOR_BYTES)
  ) u_chunk_calc (
    .i_cur_addr     (cur_addr_q),
    .i_remaining    (remaining_q),
    .i_first        (first_q),
    .o_chunk        (calc_chunk),
    .o_erase_needed (calc_erase)
  );

  // A status byte may arrive in the same cycle as the command completion.
  assign wip_now = i_flash_done ? i_flash_data[0] : wip_q;

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    active_d     = active_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    first_d      = first_q;
    chunk_d      = chunk_q;
    byte_cnt_d   = byte_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    wip_d        = wip_q;
    err_d        = err_q;
    cmd_type_d   = cmd_type_q;
    flash_cmd_d  = flash_cmd_q;
    flash_addr_d = flash_addr_q;
    flash_data_d = flash_data_q;
    data_num_d   = data_num_q;
    wr_ready_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d = ERR_OK;
          if (i_len == 24'd0) begin
            done_d = 1'b1;
          end else begin
            cur_addr_d  = i_base_addr;
            remaining_d = i_len;
            first_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_LOAD;
          end
        end
      end
      // ret selects the phase after WREN: 0 = erase, 1 = program.
      ST_LOAD: begin
        chunk_d  = calc_chunk;
        ret_d    = ~calc_erase;
        active_d = 1'b0;
        state_d  = ST_WREN;
      end
      ST_WREN: begin
        if (!active_q) begin
          cmd_type_d   = CT_CMD_ONLY;
          flash_cmd_d  = OP_WREN;
          flash_addr_d = cur_addr_q;
          data_num_d   = 8'd0;
          active_d     = 1'b1;
        end else if (i_op_done) begin
          cmd_type_d = CT_IDLE;
          active_d   = 1'b0;
          state_d    = ret_q ? ST_PROG : ST_ERASE;
        end
      end
      ST_ERASE: begin
        if (!active_q) begin
          cmd_type_d   = CT_CMD_ADDR;
          flash_cmd_d  = OP_SE;
          flash_addr_d = cur_addr_q;
          data_num_d   = 8'd0;
          active_d     = 1'b1;
        end else if (i_op_done) begin
          cmd_type_d = CT_IDLE;
          active_d   = 1'b0;
          ret_d      = 1'b0;
          poll_cnt_d = 16'd0;
          state_d    = ST_POLL;
        end
      end
      // ret selects the phase after a clean poll: 0 = WREN for program, 1 = NEXT.
      ST_POLL: begin
        if (!active_q) begin
          cmd_type_d   = CT_RD_NOADDR;
          flash_cmd_d  = OP_RDSR;
          flash_addr_d = cur_addr_q;
          data_num_d   = 8'd0;
          active_d     = 1'b1;
          poll_cnt_d   = poll_cnt_q + 16'd1;
          wip_d        = 1'b1;
        end else begin
          if (i_flash_done) wip_d = i_flash_data[0];
          if (i_op_done) begin
            cmd_type_d = CT_IDLE;
            active_d   = 1'b0;
            if (!wip_now) begin
              state_d = ret_q ? ST_NEXT : ST_WREN;
              ret_d   = 1'b1;
            end else if (poll_cnt_q >= POLL_MAX) begin
              err_d   = ERR_POLL_TO;
              state_d = ST_FINISH;
            end
          end
        end
      end
      ST_PROG: begin
        if (!active_q) begin
          if (i_wr_valid) begin
            cmd_type_d   = CT_WR_ADDR;
            flash_cmd_d  = OP_PP;
            flash_addr_d = cur_addr_q;
            data_num_d   = 8'(chunk_q - 24'd1);
            flash_data_d = i_wr_data;
            wr_ready_d   = 1'b1;
            byte_cnt_d   = 9'd1;
            active_d     = 1'b1;
          end
        end else begin
          // The byte-over of the final byte needs no refill.
          if (i_wr_byte_over && ({15'd0, byte_cnt_q} != chunk_q)) begin
            byte_cnt_d = byte_cnt_q + 9'd1;
            if (i_wr_valid) begin
              flash_data_d = i_wr_data;
              wr_ready_d   = 1'b1;
            end else begin
              err_d = ERR_UNDERRUN;
            end
          end
          if (i_op_done) begin
            cmd_type_d = CT_IDLE;
            active_d   = 1'b0;
            ret_d      = 1'b1;
            poll_cnt_d = 16'd0;
            state_d    = ST_POLL;
          end
        end
      end
      ST_NEXT: begin
        cur_addr_d  = cur_addr_q + chunk_q;
        remaining_d = remaining_q - chunk_q;
        first_d     = 1'b0;
        state_d     = (remaining_q == chunk_q) ? ST_FINISH : ST_LOAD;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      ret_q        <= 1'b0;
      active_q     <= 1'b0;
      cur_addr_q   <= 24'd0;
      remaining_q  <= 24'd0;
      first_q      <= 1'b0;
      chunk_q      <= 24'd0;
      byte_cnt_q   <= 9'd0;
      poll_cnt_q   <= 16'd0;
      wip_q        <= 1'b0;
      err_q        <= ERR_OK;
      cmd_type_q   <= CT_IDLE;
      flash_cmd_q  <= 8'd0;
      flash_addr_q <= 24'd0;
      flash_data_q <= 8'hFF;
      data_num_q   <= 8'd0;
      wr_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      active_q     <= active_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      first_q      <= first_d;
      chunk_q      <= chunk_d;
      byte_cnt_q   <= byte_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      wip_q        <= wip_d;
      err_q        <= err_d;
      cmd_type_q   <= cmd_type_d;
      flash_cmd_q  <= flash_cmd_d;
      flash_addr_q <= flash_addr_d;
      flash_data_q <= flash_data_d;
      data_num_q   <= data_num_d;
      wr_ready_q   <= wr_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_wr_ready   = wr_ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_cmd_type   = cmd_type_q;
  assign o_flash_cmd  = flash_cmd_q;
  assign o_flash_addr = flash_addr_q;
  assign o_flash_data = flash_data_q;
  assign o_data_num   = data_num_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Directed bench for flash_prog_seq with a behavioural SPI driver/flash model
// and a counting byte-stream source.
module tb_flash_prog_seq;
  import flash_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [23:0] i_base_addr = 24'd0;
  logic [23:0] i_len = 24'd0;
  logic [7:0]  i_wr_data;
  logic        i_wr_valid;
  logic        i_wr_byte_over, i_op_done, i_flash_done;
  logic [7:0]  i_flash_data;
  logic        o_wr_ready, o_busy, o_done;
  logic [1:0]  o_err;
  logic [3:0]  o_cmd_type;
  logic [7:0]  o_flash_cmd, o_flash_data, o_data_num;
  logic [23:0] o_flash_addr;

  always #5 clk = ~clk;

  flash_prog_seq #(.PAGE_BYTES(256), .SECTOR_BYTES(4096), .POLL_MAX(16'd8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
    .o_wr_ready(o_wr_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cmd_type(o_cmd_type), .o_flash_cmd(o_flash_cmd), .o_flash_addr(o_flash_addr),
    .o_flash_data(o_flash_data), .o_data_num(o_data_num),
    .i_wr_byte_over(i_wr_byte_over), .i_op_done(i_op_done),
    .i_flash_done(i_flash_done), .i_flash_data(i_flash_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream source: byte k of the stream is k*7+3.
  function automatic logic [7:0] src_byte(input int k);
    return 8'(k * 7 + 3);
  endfunction

  int   src_idx = 0;
  int   rdy_cnt = 0;
  logic drop_now = 1'b0;
  assign i_wr_data  = src_byte(src_idx);
  assign i_wr_valid = ~drop_now;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (o_wr_ready) begin
        src_idx++;
        rdy_cnt++;
      end
    end
  end

  // Driver/flash model with a command log.
  logic [63:0] lg[0:1023];
  int          lg_n = 0;
  logic [7:0]  pp_byte[0:1023];
  int          pp_n = 0;
  int          wip_left = 0;
  int          stuck_wip = 0;
  int          drop_at = -1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_cmd();
    logic [3:0]  ct;
    logic [7:0]  cmd, dn;
    logic [23:0] a;
    logic        w;
    ct = o_cmd_type; cmd = o_flash_cmd; a = o_flash_addr; dn = o_data_num;
    if (cmd != OP_SE && cmd != OP_PP) a = 24'd0;
    if (cmd != OP_RDSR && cmd != OP_PP) dn = 8'd0;
    lg[lg_n] = {20'd0, ct, cmd, a, dn};
    lg_n++;
    case (cmd)
      OP_RDSR: begin
        tick();
        if (!rst_n) return;
        if (stuck_wip != 0) w = 1'b1;
        else if (wip_left > 0) begin w = 1'b1; wip_left--; end
        else w = 1'b0;
        i_flash_data = {7'd0, w};
        i_flash_done = 1'b1;
        tick();
        i_flash_done = 1'b0;
        if (!rst_n) return;
      end
      OP_PP: begin
        for (int b = 0; b <= int'(dn); b++) begin
          tick(); tick();
          if (!rst_n) return;
          pp_byte[pp_n] = o_flash_data;
          pp_n++;
          if (b + 1 == drop_at) drop_now = 1'b1;
          i_wr_byte_over = 1'b1;
          tick();
          i_wr_byte_over = 1'b0;
          drop_now = 1'b0;
          if (!rst_n) return;
        end
        wip_left = 3;
      end
      OP_SE: begin
        tick(); tick();
        if (!rst_n) return;
        wip_left = 5;
      end
      default: begin
        tick();
        if (!rst_n) return;
      end
    endcase
    i_op_done = 1'b1;
    tick();
    i_op_done = 1'b0;
    if (!rst_n) return;
    check("cmd_drop", {60'd0, o_cmd_type}, 64'd0);
  endtask

  initial begin
    i_wr_byte_over = 1'b0; i_op_done = 1'b0; i_flash_done = 1'b0; i_flash_data = 8'd0;
    forever begin
      tick();
      if (rst_n && o_cmd_type[3]) run_cmd();
    end
  end

  // Expected command sequence.
  logic [63:0] exp_q[$];

  task automatic ex(input logic [3:0] ct, input logic [7:0] cmd, input logic [23:0] a, input logic [7:0] dn);
    exp_q.push_back({20'd0, ct, cmd, a, dn});
  endtask
  task automatic ex_wren();
    ex(CT_CMD_ONLY, OP_WREN, 24'd0, 8'd0);
  endtask
  task automatic ex_se(input logic [23:0] a);
    ex(CT_CMD_ADDR, OP_SE, a, 8'd0);
  endtask
  task automatic ex_rdsr(input int n);
    for (int i = 0; i < n; i++) ex(CT_RD_NOADDR, OP_RDSR, 24'd0, 8'd0);
  endtask
  task automatic ex_pp(input logic [23:0] a, input logic [7:0] dn);
    ex(CT_WR_ADDR, OP_PP, a, dn);
  endtask

  task automatic cmp_seq(input string tag, input int lb);
    check({tag, "_ncmd"}, 64'(lg_n - lb), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && lb + i < lg_n; i++)
      check($sformatf("%s_cmd%0d", tag, i), lg[lb + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic start(input logic [23:0] b, input logic [23:0] l);
    i_base_addr = b; i_len = l; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_err);
    bit seen = 1'b0;
    for (int n = 0; n < 20000 && !seen; n++) begin
      tick();
      if (o_done) begin
        seen = 1'b1;
        check({tag, "_err"}, {62'd0, o_err}, {62'd0, exp_err});
        check({tag, "_busy_at_done"}, {63'd0, o_busy}, 64'd0);
      end
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_type"}, {60'd0, o_cmd_type}, 64'd0);
    check({tag, "_flash_cmd"}, {56'd0, o_flash_cmd}, 64'd0);
    check({tag, "_flash_addr"}, {40'd0, o_flash_addr}, 64'd0);
    check({tag, "_flash_data"}, {56'd0, o_flash_data}, 64'hFF);
    check({tag, "_data_num"}, {56'd0, o_data_num}, 64'd0);
    check({tag, "_wr_ready"}, {63'd0, o_wr_ready}, 64'd0);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    check({tag, "_done"}, {63'd0, o_done}, 64'd0);
    check({tag, "_err"}, {62'd0, o_err}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb, pb, sb, rb, mism;

    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Zero length: immediate done, never busy.
    start(24'h000123, 24'd0);
    check("zero_done", {63'd0, o_done}, 64'd1);
    check("zero_err", {62'd0, o_err}, 64'd0);
    check("zero_busy", {63'd0, o_busy}, 64'd0);
    tick();
    check("zero_done_pulse", {63'd0, o_done}, 64'd0);

    // One full page at address 0.
    lb = lg_n; pb = pp_n; sb = src_idx; rb = rdy_cnt;
    start(24'h000000, 24'd256);
    check("t1_busy_rise", {63'd0, o_busy}, 64'd1);
    wait_done("t1", ERR_OK);
    ex_wren(); ex_se(24'h000000); ex_rdsr(6); ex_wren(); ex_pp(24'h000000, 8'd255); ex_rdsr(4);
    cmp_seq("t1", lb);
    check("t1_wr_ready_cnt", 64'(rdy_cnt - rb), 64'd256);
    mism = 0;
    for (int k = 0; k < 256; k++) if (pp_byte[pb + k] !== src_byte(sb + k)) mism++;
    check("t1_data_mism", 64'(mism), 64'd0);

    // Crosses a page boundary inside one sector.
    lb = lg_n;
    start(24'h0000F0, 24'd32);
    wait_done("t2", ERR_OK);
    ex_wren(); ex_se(24'h0000F0); ex_rdsr(6); ex_wren(); ex_pp(24'h0000F0, 8'd15); ex_rdsr(4);
    ex_wren(); ex_pp(24'h000100, 8'd15); ex_rdsr(4);
    cmp_seq("t2", lb);

    // Crosses a sector boundary: second erase at 0x1000.
    lb = lg_n;
    start(24'h000FF0, 24'd32);
    wait_done("t3", ERR_OK);
    ex_wren(); ex_se(24'h000FF0); ex_rdsr(6); ex_wren(); ex_pp(24'h000FF0, 8'd15); ex_rdsr(4);
    ex_wren(); ex_se(24'h001000); ex_rdsr(6); ex_wren(); ex_pp(24'h001000, 8'd15); ex_rdsr(4);
    cmp_seq("t3", lb);

    // WIP stuck: 8 status reads then timeout, no program.
    lb = lg_n; stuck_wip = 1;
    start(24'h002000, 24'd16);
    wait_done("t4", ERR_POLL_TO);
    stuck_wip = 0;
    ex_wren(); ex_se(24'h002000); ex_rdsr(8);
    cmp_seq("t4", lb);

    // Stream underrun at byte 5: stale byte 4 is sent again.
    lb = lg_n; pb = pp_n; sb = src_idx; rb = rdy_cnt; drop_at = 5;
    start(24'h003000, 24'd16);
    wait_done("t5", ERR_UNDERRUN);
    drop_at = -1;
    ex_wren(); ex_se(24'h003000); ex_rdsr(6); ex_wren(); ex_pp(24'h003000, 8'd15); ex_rdsr(4);
    cmp_seq("t5", lb);
    check("t5_bytes_shifted", 64'(pp_n - pb), 64'd16);
    check("t5_wr_ready_cnt", 64'(rdy_cnt - rb), 64'd15);
    mism = 0;
    for (int k = 0; k < 16; k++)
      if (pp_byte[pb + k] !== src_byte(sb + ((k <= 4) ? k : k - 1))) mism++;
    check("t5_data_mism", 64'(mism), 64'd0);

    // Asynchronous reset during PROG, then a clean restart.
    start(24'h004000, 24'd16);
    begin
      bit seen_pp = 1'b0;
      for (int n = 0; n < 500 && !seen_pp; n++) begin
        tick();
        if (o_cmd_type == CT_WR_ADDR) seen_pp = 1'b1;
      end
      check("t6_pp_seen", {63'd0, seen_pp}, 64'd1);
    end
    tick(); tick();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    lb = lg_n; rb = rdy_cnt;
    start(24'h005000, 24'd8);
    wait_done("t6", ERR_OK);
    ex_wren(); ex_se(24'h005000); ex_rdsr(6); ex_wren(); ex_pp(24'h005000, 8'd7); ex_rdsr(4);
    cmp_seq("t6", lb);
    check("t6_wr_ready_cnt", 64'(rdy_cnt - rb), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
